// File: rtl/mips_mem_pkg.sv
// Shared types and defaults for the data-memory side of the pipeline.
package mips_mem_pkg;

  localparam int unsigned SB_DEPTH = 4;
  localparam int unsigned SB_AW    = 32;
  localparam int unsigned SB_DW    = 32;

  // Word address: byte address with the two offset bits dropped.
  typedef logic [SB_AW-3:0] word_addr_t;

  typedef struct packed {
    word_addr_t        addr;
    logic [SB_DW-1:0]  data;
  } sb_entry_t;

  // Slot index to age (0 = oldest) relative to the head pointer; DEPTH is a power of two.
  function automatic int unsigned sb_age(input int unsigned slot, input int unsigned head,
                                         input int unsigned depth);
    return (slot - head) & (depth - 1);
  endfunction

endpackage

// File: rtl/sb_fwd_match.sv
// Youngest-match search over the store buffer for load forwarding.
module sb_fwd_match
  import mips_mem_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH,
  parameter int unsigned AW    = SB_AW,
  parameter int unsigned DW    = SB_DW
) (
  input  logic [AW-3:0]              ent_addr_i [DEPTH],
  input  logic [DW-1:0]              ent_data_i [DEPTH],
  input  logic [DEPTH-1:0]           valid_i,
  input  logic [$clog2(DEPTH)-1:0]   head_i,
  input  logic [AW-3:0]              lookup_i,
  output logic                       hit_o,
  output logic [DW-1:0]              data_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW-1:0] idx;

  // Walk oldest to youngest; a later match overrides, so the youngest hit wins.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_i + PW'(i);
      if (valid_i[idx] && (ent_addr_i[idx] == lookup_i)) begin
        hit_o  = 1'b1;
        data_o = ent_data_i[idx];
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer between the MEM stage and a single-port data memory.
// Stores are queued and drained in program order in cycles where the port
// is not claimed by a load; loads forward from the youngest matching entry.
module store_buffer
  import mips_mem_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH,
  parameter int unsigned AW    = SB_AW,
  parameter int unsigned DW    = SB_DW
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     cpu_we,
  input  logic                     cpu_re,
  input  logic [AW-1:0]            cpu_a,
  input  logic [DW-1:0]            cpu_wd,
  output logic [DW-1:0]            cpu_rd,
  output logic                     stall,
  output logic                     mem_we,
  output logic [AW-1:0]            mem_a,
  output logic [DW-1:0]            mem_wd,
  input  logic [DW-1:0]            mem_rd,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-3:0]   ent_addr_q [DEPTH];
  logic [AW-3:0]   ent_addr_d [DEPTH];
  logic [DW-1:0]   ent_data_q [DEPTH];
  logic [DW-1:0]   ent_data_d [DEPTH];

  logic            full;
  logic            accept;
  logic            drain;
  logic            load_served;
  logic [DEPTH-1:0] valid;
  logic [PW-1:0]   age;
  logic            fwd_hit;
  logic [DW-1:0]   fwd_data;

  // Byte-offset bits never take part in word-granular buffering.
  logic unused_byte_off;
  assign unused_byte_off = ^cpu_a[1:0];

  // Port arbitration: full forces a drain, any load request owns the port,
  // otherwise a pending store drains.
  always_comb begin
    full        = (count_q == CW'(DEPTH));
    accept      = cpu_we & ~full;
    load_served = cpu_re & ~cpu_we & ~full;
    drain       = full | (~cpu_re & (count_q != '0));
  end

  // Valid mask: slot is live if its age from head is below the occupancy.
  always_comb begin
    valid = '0;
    age   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      age      = PW'(i) - head_q;
      valid[i] = ({1'b0, age} < count_q);
    end
  end

  sb_fwd_match #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_fwd_match (
    .ent_addr_i (ent_addr_q),
    .ent_data_i (ent_data_q),
    .valid_i    (valid),
    .head_i     (head_q),
    .lookup_i   (cpu_a[AW-1:2]),
    .hit_o      (fwd_hit),
    .data_o     (fwd_data)
  );

  // Pointer and occupancy next state; pointers wrap naturally at DEPTH.
  always_comb begin
    head_d  = head_q + PW'(drain);
    tail_d  = tail_q + PW'(accept);
    count_d = count_q + CW'(accept) - CW'(drain);
  end

  // Entry storage next state: write the accepted store at the tail slot.
  always_comb begin
    ent_addr_d = ent_addr_q;
    ent_data_d = ent_data_q;
    if (accept) begin
      ent_addr_d[tail_q] = cpu_a[AW-1:2];
      ent_data_d[tail_q] = cpu_wd;
    end
  end

  // Control state; reset discards every pending store immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payload needs no reset: occupancy alone decides what is live.
  always_ff @(posedge clk) begin
    ent_addr_q <= ent_addr_d;
    ent_data_q <= ent_data_d;
  end

  // Outputs toward the CPU and the data memory.
  always_comb begin
    stall  = full & (cpu_we | cpu_re);
    empty  = (count_q == '0);
    count  = count_q;
    mem_we = drain;
    mem_a  = drain ? {ent_addr_q[head_q], 2'b00} : cpu_a;
    mem_wd = ent_data_q[head_q];
    cpu_rd = (load_served && fwd_hit) ? fwd_data : mem_rd;
  end

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer with a behavioural single-port dmem.
module tb_store_buffer;

  logic        clk;
  logic        reset_n;
  logic        cpu_we;
  logic        cpu_re;
  logic [31:0] cpu_a;
  logic [31:0] cpu_wd;
  logic [31:0] cpu_rd;
  logic        stall;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;
  logic        empty;
  logic [2:0]  count;

  logic        mem_init;
  logic [31:0] dmem [256];

  int checks;
  int failures;

  logic [63:0] wr_exp [$];
  logic [31:0] ld_exp [$];

  store_buffer #(
    .DEPTH (4),
    .AW    (32),
    .DW    (32)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .cpu_we  (cpu_we),
    .cpu_re  (cpu_re),
    .cpu_a   (cpu_a),
    .cpu_wd  (cpu_wd),
    .cpu_rd  (cpu_rd),
    .stall   (stall),
    .mem_we  (mem_we),
    .mem_a   (mem_a),
    .mem_wd  (mem_wd),
    .mem_rd  (mem_rd),
    .empty   (empty),
    .count   (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int i);
    return (i == 16) ? 32'hAABBCCDD : (32'hD0D0_0000 | 32'(i));
  endfunction

  // Data memory: combinational read, write on the rising edge.
  assign mem_rd = dmem[mem_a[9:2]];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) dmem[i] <= init_val(i);
    end else if (mem_we) begin
      dmem[mem_a[9:2]] <= mem_wd;
    end
  end

  logic tb_unused;
  assign tb_unused = ^{mem_a[31:10], mem_a[1:0]};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One cycle of stimulus; expectations are queued at issue time.
  task automatic step(input logic we, input logic re, input logic [31:0] a,
                      input logic [31:0] wd, input logic exp_stall,
                      input logic [31:0] exp_rd);
    @(posedge clk);
    #1;
    cpu_we = we;
    cpu_re = re;
    cpu_a  = a;
    cpu_wd = wd;
    if (we && !exp_stall) wr_exp.push_back({a[31:2], 2'b00, wd});
    if (re && !we && !exp_stall) ld_exp.push_back(exp_rd);
    @(negedge clk);
    chk("stall", 32'(stall), 32'(exp_stall));
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  // Monitor: every dmem write and every served load is checked against the queues.
  always @(negedge clk) begin
    if (reset_n) begin
      if (mem_we) begin
        if (wr_exp.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL drain: unexpected dmem write a=0x%08h wd=0x%08h", mem_a, mem_wd);
        end else begin
          logic [63:0] e;
          e = wr_exp.pop_front();
          chk("drain_addr", mem_a, e[63:32]);
          chk("drain_data", mem_wd, e[31:0]);
        end
      end
      if (cpu_re && !cpu_we && !stall) begin
        if (ld_exp.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL load: unexpected served load rd=0x%08h", cpu_rd);
        end else begin
          logic [31:0] r;
          r = ld_exp.pop_front();
          chk("load_rd", cpu_rd, r);
        end
      end
      if (stall) chk("stall_only_when_full", 32'(count), 32'd4);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit, got running, expected finished");
    $fatal(1);
  end

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    mem_init = 1'b1;
    cpu_we   = 1'b0;
    cpu_re   = 1'b0;
    cpu_a    = 32'h40;
    cpu_wd   = 32'h0;
    @(posedge clk);
    @(posedge clk);
    #1 mem_init = 1'b0;
    @(negedge clk);
    // Reset state.
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_mem_a", mem_a, 32'h40);
    chk("rst_cpu_rd", cpu_rd, 32'hAABBCCDD);
    reset_n = 1'b1;

    // Single store drains on the next cycle.
    step(1'b1, 1'b0, 32'h4, 32'h12345678, 1'b0, 32'h0);
    idle();
    chk("t1_mem_we", 32'(mem_we), 32'd1);
    chk("t1_mem_a", mem_a, 32'h4);
    chk("t1_mem_wd", mem_wd, 32'h12345678);
    idle();
    chk("t1_empty", 32'(empty), 32'd1);
    chk("t1_dmem", dmem[1], 32'h12345678);

    // Two stores to one address held in the buffer; load sees the youngest.
    step(1'b1, 1'b1, 32'h8, 32'h11, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h8, 32'h22, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h8, 32'h0, 1'b0, 32'h22);
    chk("t2_count", 32'(count), 32'd2);
    chk("t2_no_drain", 32'(mem_we), 32'd0);
    idle();
    idle();
    idle();
    chk("t2_empty", 32'(empty), 32'd1);
    chk("t2_dmem", dmem[2], 32'h22);

    // Fill to DEPTH; fifth store stalls and the head drains that cycle.
    for (int k = 0; k < 4; k++)
      step(1'b1, 1'b1, 32'h10 + 32'(4 * k), 32'h100 + 32'(k), 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h20, 32'h104, 1'b1, 32'h0);
    chk("t3_count_full", 32'(count), 32'd4);
    chk("t3_full_drain_we", 32'(mem_we), 32'd1);
    chk("t3_full_drain_a", mem_a, 32'h10);
    step(1'b1, 1'b1, 32'h20, 32'h104, 1'b0, 32'h0);
    chk("t3_count_retry", 32'(count), 32'd3);
    chk("t3_retry_no_drain", 32'(mem_we), 32'd0);
    for (int k = 0; k < 5; k++) idle();
    chk("t3_empty", 32'(empty), 32'd1);
    for (int k = 0; k < 5; k++) chk("t3_dmem", dmem[4 + k], 32'h100 + 32'(k));

    // Unbuffered load with stores pending reads dmem and blocks draining.
    step(1'b1, 1'b1, 32'h50, 32'h5050, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h54, 32'h5454, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h40, 32'h0, 1'b0, 32'hAABBCCDD);
    chk("t4_no_drain", 32'(mem_we), 32'd0);
    chk("t4_count", 32'(count), 32'd2);
    idle();
    chk("t4_resume_we", 32'(mem_we), 32'd1);
    chk("t4_resume_a", mem_a, 32'h50);
    idle();
    idle();
    chk("t4_empty", 32'(empty), 32'd1);

    // Asynchronous reset with three stores pending discards them.
    step(1'b1, 1'b1, 32'h60, 32'h6060, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h64, 32'h6464, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h68, 32'h6868, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    cpu_we = 1'b0;
    cpu_re = 1'b0;
    chk("t5_count_pre", 32'(count), 32'd3);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_count", 32'(count), 32'd0);
    chk("t5_empty", 32'(empty), 32'd1);
    chk("t5_mem_we", 32'(mem_we), 32'd0);
    wr_exp.delete();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) chk("t5_dmem", dmem[24 + k], init_val(24 + k));

    // Pointer wrap: ten stores with idle cycles; drain order checked by monitor.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, (i % 2) == 0, 32'h100 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 1'b0, 32'h0);
      if (i % 2 == 1) idle();
    end
    for (int k = 0; k < 3; k++) idle();
    chk("t6_count", 32'(count), 32'd0);
    chk("t6_empty", 32'(empty), 32'd1);
    for (int i = 0; i < 10; i++) chk("t6_dmem", dmem[64 + i], 32'hC0DE_0000 + 32'(i));

    chk("wr_queue_drained", 32'(wr_exp.size()), 32'd0);
    chk("ld_queue_drained", 32'(ld_exp.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
